sun_pll_rosc_cal: RTL and testbench

Digital calibration controller for the PLL ring oscillator in `SUN_PLL_SKY130NM`. It powers up a trimmable ring oscillator and measures its divided output against a window of reference clocks. A successive-approximation search sets the trim code so the measured edge count matches a programmed target. It then verifies the final code and reports lock or failure, generalising the fixed-length oscillator with a parametrised trim width, measurement window and tolerance.

---
 rtl/sun_pll_rosc_cal.sv | 227 ++++++++++++++++++++++
 tb/tb_sun_pll_rosc_cal.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sun_pll_rosc_cal.sv
`default_nettype none
// ============================================================================
// Module   : sun_pll_rosc_cal
// Purpose  : Calibration controller for the PLL ring oscillator. It counts
//            rising edges of the divided oscillator output over a window of
//            reference clocks and runs a successive-approximation search on
//            the trim code, then re-measures the final code and reports lock
//            or failure.
// Ports    : CK          reference clock (single clock domain)
//            RST         synchronous active-high reset
//            PWRUP       block enable, low forces IDLE
//            CAL_START   level-sampled start request
//            TARGET      desired edge count per window
//            CK_ROSC_S   divided oscillator output (asynchronous to CK)
//            PWRUP_ROSC  oscillator enable
//            TRIM        oscillator trim code (higher = faster)
//            COUNT       last completed measurement
//            CAL_BUSY    calibration in progress
//            LOCK        calibration finished within tolerance
//            CAL_FAIL    calibration finished out of tolerance
// Revision : 1.0 - initial release
// ============================================================================
module sun_pll_rosc_cal #(
  parameter int TRIM_W = 4,
  parameter int CNT_W  = 12,
  parameter int WINDOW = 256,
  parameter int SETTLE = 16,
  parameter int TOL    = 2
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              PWRUP,
  input  logic              CAL_START,
  input  logic [CNT_W-1:0]  TARGET,
  input  logic              CK_ROSC_S,
  output logic              PWRUP_ROSC,
  output logic [TRIM_W-1:0] TRIM,
  output logic [CNT_W-1:0]  COUNT,
  output logic              CAL_BUSY,
  output logic              LOCK,
  output logic              CAL_FAIL
);

  // One shared down-counter times both the settle and measurement phases,
  // so it is sized for the longer of the two.
  localparam int c_TMR_MAX = (WINDOW > SETTLE) ? WINDOW : SETTLE;
  localparam int c_TMR_W   = $clog2(c_TMR_MAX);
  localparam int c_K_W     = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

  localparam logic [c_TMR_W-1:0] c_SETTLE_LD = c_TMR_W'(SETTLE - 1);
  localparam logic [c_TMR_W-1:0] c_WINDOW_LD = c_TMR_W'(WINDOW - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE   = c_TMR_W'(1);
  localparam logic [c_K_W-1:0]   c_K_MSB     = c_K_W'(TRIM_W - 1);
  localparam logic [c_K_W-1:0]   c_K_ONE     = c_K_W'(1);
  localparam logic [TRIM_W-1:0]  c_TRIM_MSB  = TRIM_W'(1) << (TRIM_W - 1);
  localparam logic [CNT_W-1:0]   c_CNT_MAX   = '1;
  localparam logic [CNT_W-1:0]   c_CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]     c_TOL       = (CNT_W + 1)'(TOL);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_MEASURE = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4,
    S_FAIL    = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          sync_q;
  logic [c_TMR_W-1:0]  timer_q, timer_d;
  logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
  logic [c_K_W-1:0]    k_q, k_d;
  logic                verify_q, verify_d;
  logic [TRIM_W-1:0]   trim_q, trim_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                pwrup_rosc_q, pwrup_rosc_d;
  logic                busy_q, busy_d;
  logic                lock_q, lock_d;
  logic                fail_q, fail_d;

  logic                w_rise;
  logic [CNT_W:0]      w_abs_diff;
  logic                w_in_tol;

  // sync_q[0..1] form the synchroniser; sync_q[2] only remembers the previous
  // synchronised level for rising-edge detection.
  always_ff @(posedge CK) begin
    if (RST) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], CK_ROSC_S};
    end
  end

  assign w_rise = sync_q[1] & ~sync_q[2];

  // Magnitude of (count - target) at CNT_W+1 bits; the subtraction is always
  // larger-minus-smaller so it cannot wrap.
  assign w_abs_diff = (edge_cnt_q >= TARGET) ?
                      ({1'b0, edge_cnt_q} - {1'b0, TARGET}) :
                      ({1'b0, TARGET} - {1'b0, edge_cnt_q});
  assign w_in_tol   = (w_abs_diff <= c_TOL);

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    edge_cnt_d = edge_cnt_q;
    k_d        = k_q;
    verify_d   = verify_q;
    trim_d     = trim_q;
    count_d    = count_q;

    if (!PWRUP) begin
      // Trim and last count are kept so the oscillator can be re-enabled at
      // its previous setting.
      state_d    = S_IDLE;
      edge_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_FAIL: begin
          if (CAL_START) begin
            state_d    = S_SETTLE;
            timer_d    = c_SETTLE_LD;
            k_d        = c_K_MSB;
            verify_d   = 1'b0;
            trim_d     = c_TRIM_MSB;
            edge_cnt_d = '0;
          end
        end

        S_SETTLE: begin
          edge_cnt_d = '0;
          if (timer_q == '0) begin
            state_d = S_MEASURE;
            timer_d = c_WINDOW_LD;
          end else begin
            timer_d = timer_q - c_TMR_ONE;
          end
        end

        S_MEASURE: begin
          if (w_rise && (edge_cnt_q != c_CNT_MAX)) begin
            edge_cnt_d = edge_cnt_q + c_CNT_ONE;
          end
          if (timer_q == '0) begin
            state_d = S_COMPARE;
          end else begin
            timer_d = timer_q - c_TMR_ONE;
          end
        end

        S_COMPARE: begin
          count_d = edge_cnt_q;
          if (!verify_q) begin
            // Too fast: drop the bit under test. Then try the next lower bit,
            // or, once bit 0 is resolved, re-measure the final code.
            if (edge_cnt_q > TARGET) begin
              trim_d[k_q] = 1'b0;
            end
            if (k_q != '0) begin
              trim_d[k_q - c_K_ONE] = 1'b1;
              k_d                   = k_q - c_K_ONE;
            end else begin
              verify_d = 1'b1;
            end
            state_d = S_SETTLE;
            timer_d = c_SETTLE_LD;
          end else begin
            state_d = w_in_tol ? S_DONE : S_FAIL;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Status flags are registered copies of the next state so they line up
  // exactly with the state transition edge.
  always_comb begin
    pwrup_rosc_d = PWRUP;
    busy_d       = (state_d == S_SETTLE) || (state_d == S_MEASURE) ||
                   (state_d == S_COMPARE);
    lock_d       = (state_d == S_DONE);
    fail_d       = (state_d == S_FAIL);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      edge_cnt_q   <= '0;
      k_q          <= '0;
      verify_q     <= 1'b0;
      trim_q       <= '0;
      count_q      <= '0;
      pwrup_rosc_q <= 1'b0;
      busy_q       <= 1'b0;
      lock_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      edge_cnt_q   <= edge_cnt_d;
      k_q          <= k_d;
      verify_q     <= verify_d;
      trim_q       <= trim_d;
      count_q      <= count_d;
      pwrup_rosc_q <= pwrup_rosc_d;
      busy_q       <= busy_d;
      lock_q       <= lock_d;
      fail_q       <= fail_d;
    end
  end

  assign PWRUP_ROSC = pwrup_rosc_q;
  assign TRIM       = trim_q;
  assign COUNT      = count_q;
  assign CAL_BUSY   = busy_q;
  assign LOCK       = lock_q;
  assign CAL_FAIL   = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_sun_pll_rosc_cal.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module   : tb_sun_pll_rosc_cal
// Purpose  : Self-checking bench for sun_pll_rosc_cal. A behavioural
//            oscillator produces (16*TRIM + 7.5) rising edges per measurement
//            window, so every window sees 16*TRIM+7 or 16*TRIM+8 edges. The
//            window is widened to 1024 cycles to keep the oscillator below
//            CK/4. A second instance with an 8-bit counter exercises
//            saturation with a fixed 400-edges-per-window oscillator.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sun_pll_rosc_cal;

  localparam int TRIM_W   = 4;
  localparam int CNT_W    = 12;
  localparam int WINDOW   = 1024;
  localparam int SETTLE   = 16;
  localparam int TOL      = 2;
  localparam int CAL_CYC  = (TRIM_W + 1) * (SETTLE + WINDOW + 1);

  localparam int S_TRIM_W = 2;
  localparam int S_CNT_W  = 8;
  localparam int S_WINDOW = 2048;
  localparam int S_SETTLE = 4;
  localparam int S_STEP   = S_SETTLE + S_WINDOW + 1;
  localparam int S_CAL    = (S_TRIM_W + 1) * S_STEP;

  logic              CK;
  logic              RST;
  logic              PWRUP;
  logic              CAL_START;
  logic [CNT_W-1:0]  TARGET;
  logic              CK_ROSC_S;
  logic              PWRUP_ROSC;
  logic [TRIM_W-1:0] TRIM;
  logic [CNT_W-1:0]  COUNT;
  logic              CAL_BUSY;
  logic              LOCK;
  logic              CAL_FAIL;

  logic                s_PWRUP;
  logic                s_START;
  logic [S_CNT_W-1:0]  s_TARGET;
  logic                s_ROSC;
  logic                s_PWRUP_ROSC;
  logic [S_TRIM_W-1:0] s_TRIM;
  logic [S_CNT_W-1:0]  s_COUNT;
  logic                s_BUSY;
  logic                s_LOCK;
  logic                s_FAIL;

  int n_tests = 0;
  int n_fail  = 0;

  sun_pll_rosc_cal #(
    .TRIM_W (TRIM_W),
    .CNT_W  (CNT_W),
    .WINDOW (WINDOW),
    .SETTLE (SETTLE),
    .TOL    (TOL)
  ) dut (
    .CK         (CK),
    .RST        (RST),
    .PWRUP      (PWRUP),
    .CAL_START  (CAL_START),
    .TARGET     (TARGET),
    .CK_ROSC_S  (CK_ROSC_S),
    .PWRUP_ROSC (PWRUP_ROSC),
    .TRIM       (TRIM),
    .COUNT      (COUNT),
    .CAL_BUSY   (CAL_BUSY),
    .LOCK       (LOCK),
    .CAL_FAIL   (CAL_FAIL)
  );

  sun_pll_rosc_cal #(
    .TRIM_W (S_TRIM_W),
    .CNT_W  (S_CNT_W),
    .WINDOW (S_WINDOW),
    .SETTLE (S_SETTLE),
    .TOL    (2)
  ) dut_sat (
    .CK         (CK),
    .RST        (RST),
    .PWRUP      (s_PWRUP),
    .CAL_START  (s_START),
    .TARGET     (s_TARGET),
    .CK_ROSC_S  (s_ROSC),
    .PWRUP_ROSC (s_PWRUP_ROSC),
    .TRIM       (s_TRIM),
    .COUNT      (s_COUNT),
    .CAL_BUSY   (s_BUSY),
    .LOCK       (s_LOCK),
    .CAL_FAIL   (s_FAIL)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Phase-accumulator oscillators stepped every 1 ns, offset from CK edges.
  real ph_main;
  initial begin
    CK_ROSC_S = 1'b0;
    ph_main   = 0.0;
    #0.3;
    forever begin
      #1;
      if (PWRUP_ROSC === 1'b1) begin
        ph_main = ph_main + (16.0 * TRIM + 7.5) * 2.0 / (WINDOW * 10.0);
        if (ph_main >= 1.0) begin
          ph_main   = ph_main - 1.0;
          CK_ROSC_S = ~CK_ROSC_S;
        end
      end
    end
  end

  real ph_sat;
  initial begin
    s_ROSC = 1'b0;
    ph_sat = 0.0;
    #0.7;
    forever begin
      #1;
      if (s_PWRUP_ROSC === 1'b1) begin
        ph_sat = ph_sat + 400.0 * 2.0 / (S_WINDOW * 10.0);
        if (ph_sat >= 1.0) begin
          ph_sat = ph_sat - 1.0;
          s_ROSC = ~s_ROSC;
        end
      end
    end
  end

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_in(input string tag, input logic [31:0] obs, input int lo, input int hi);
    n_tests++;
    assert ((obs >= 32'(lo)) && (obs <= 32'(hi))) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Reference: binary search over trim bits, MSB first, keeping a bit only if
  // the nominal rate 16*t+7.5 does not exceed the target (doubled to stay
  // in integers).
  function automatic int ref_trim(input int tgt);
    int t;
    t = 0;
    for (int b = TRIM_W - 1; b >= 0; b--) begin
      t = t | (1 << b);
      if (32 * t + 15 > 2 * tgt) t = t & ~(1 << b);
    end
    return t;
  endfunction

  task automatic start_cal(input int tgt, input bit hold);
    TARGET    = CNT_W'(tgt);
    CAL_START = 1'b1;
    tick();
    chk("start_busy", 32'(CAL_BUSY), 1);
    chk("start_trim", 32'(TRIM), 32'(1 << (TRIM_W - 1)));
    chk("start_lock", 32'(LOCK), 0);
    chk("start_fail", 32'(CAL_FAIL), 0);
    if (!hold) CAL_START = 1'b0;
  endtask

  task automatic wait_done();
    int cyc;
    bit dropped;
    cyc     = 0;
    dropped = 1'b0;
    while (!(LOCK === 1'b1 || CAL_FAIL === 1'b1) && cyc < CAL_CYC + 50) begin
      if (CAL_BUSY !== 1'b1) dropped = 1'b1;
      tick();
      cyc++;
    end
    chk("cal_cycles", 32'(cyc), 32'(CAL_CYC));
    chk("busy_held", 32'(dropped), 0);
  endtask

  task automatic check_result(input int tgt);
    int  t;
    int  d;
    bit  lk;
    t  = ref_trim(tgt);
    d  = 16 * t + 8 - tgt;
    if (d < 0) d = -d;
    lk = (d <= TOL);
    chk("res_trim", 32'(TRIM), 32'(t));
    chk("res_lock", 32'(LOCK), 32'(lk));
    chk("res_fail", 32'(CAL_FAIL), 32'(!lk));
    chk("res_busy", 32'(CAL_BUSY), 0);
    chk_in("res_count", 32'(COUNT), 16 * t + 7, 16 * t + 8);
  endtask

  initial begin
    int tgt;
    int cyc;
    logic [31:0] trim1;
    logic [31:0] cnt1;

    RST       = 1'b1;
    PWRUP     = 1'b1;
    CAL_START = 1'b0;
    TARGET    = '0;
    s_PWRUP   = 1'b1;
    s_START   = 1'b0;
    s_TARGET  = '0;

    // Reset held for two cycles with PWRUP high.
    tick();
    tick();
    chk("rst_trim", 32'(TRIM), 0);
    chk("rst_count", 32'(COUNT), 0);
    chk("rst_pwrup_rosc", 32'(PWRUP_ROSC), 0);
    chk("rst_busy", 32'(CAL_BUSY), 0);
    chk("rst_lock", 32'(LOCK), 0);
    chk("rst_fail", 32'(CAL_FAIL), 0);
    RST = 1'b0;
    tick();
    chk("idle_pwrup_rosc", 32'(PWRUP_ROSC), 1);
    chk("idle_busy", 32'(CAL_BUSY), 0);

    // Reachable target: search 8,4,6,7 -> 6.
    start_cal(104, 1'b0);
    wait_done();
    check_result(104);

    // Unreachable target: all bits kept, verify out of tolerance.
    start_cal(300, 1'b0);
    wait_done();
    check_result(300);

    // PWRUP dropped 10 cycles into the second MEASURE. After the first step
    // TRIM is 4 (code 8 gives ~136 edges > 104).
    start_cal(104, 1'b0);
    repeat (SETTLE + WINDOW + 1 + SETTLE + 10) tick();
    PWRUP = 1'b0;
    tick();
    chk("drop_busy", 32'(CAL_BUSY), 0);
    chk("drop_pwrup_rosc", 32'(PWRUP_ROSC), 0);
    chk("drop_lock", 32'(LOCK), 0);
    chk("drop_fail", 32'(CAL_FAIL), 0);
    chk("drop_trim", 32'(TRIM), 4);
    tick();
    chk("drop_trim_hold", 32'(TRIM), 4);
    PWRUP = 1'b1;
    start_cal(104, 1'b0);
    wait_done();
    check_result(104);

    // CAL_START held high throughout, then immediate restart from DONE.
    start_cal(104, 1'b1);
    wait_done();
    check_result(104);
    tick();
    chk("restart_busy", 32'(CAL_BUSY), 1);
    chk("restart_lock", 32'(LOCK), 0);
    chk("restart_trim", 32'(TRIM), 8);
    CAL_START = 1'b0;
    wait_done();
    check_result(104);

    // Random targets, avoiding values where the +-1 count spread would make
    // the expected outcome ambiguous.
    for (int i = 0; i < 3; i++) begin
      tgt = $urandom_range(0, 400);
      while ((tgt % 16 == 5) || (tgt % 16 == 7) || (tgt % 16 == 10))
        tgt = $urandom_range(0, 400);
      start_cal(tgt, 1'b0);
      wait_done();
      check_result(tgt);
    end

    // Saturation on the 8-bit instance: 400 edges per window clamp at 255,
    // every search bit is cleared, and verify fails.
    s_TARGET = 8'd200;
    s_START  = 1'b1;
    tick();
    chk("sat_busy", 32'(s_BUSY), 1);
    chk("sat_trim_init", 32'(s_TRIM), 2);
    s_START = 1'b0;
    cyc   = 0;
    trim1 = '0;
    cnt1  = '0;
    while (!(s_LOCK === 1'b1 || s_FAIL === 1'b1) && cyc < S_CAL + 50) begin
      tick();
      cyc++;
      if (cyc == S_STEP) begin
        trim1 = 32'(s_TRIM);
        cnt1  = 32'(s_COUNT);
      end
    end
    chk("sat_cycles", 32'(cyc), 32'(S_CAL));
    chk("sat_step1_trim", trim1, 1);
    chk("sat_step1_count", cnt1, 255);
    chk("sat_trim", 32'(s_TRIM), 0);
    chk("sat_count", 32'(s_COUNT), 255);
    chk("sat_fail", 32'(s_FAIL), 1);
    chk("sat_lock", 32'(s_LOCK), 0);

    // Reset mid-calibration wins over PWRUP and returns to reset values.
    start_cal(104, 1'b0);
    repeat (100) tick();
    RST = 1'b1;
    tick();
    chk("midrst_busy", 32'(CAL_BUSY), 0);
    chk("midrst_trim", 32'(TRIM), 0);
    chk("midrst_count", 32'(COUNT), 0);
    chk("midrst_pwrup_rosc", 32'(PWRUP_ROSC), 0);
    RST = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
